// File: rtl/alu_mem_datapath_pkg.sv
// alu_mem_datapath_pkg
// Shared definitions for the execute/memory slice of the LEGv8 datapath:
// ALU control codes, main-control ALUOp encodings and the opcode constants
// decoded by the ALU control.
package alu_mem_datapath_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_PASSB   = 4'b0111,
    ALU_INVALID = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,  // LDUR/STUR address generation
    ALUOP_CBZ   = 2'b01,  // pass operand B for the zero test
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  // R-type opcodes (all 11 bits significant)
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;

  // I-type opcodes; bit 0 is part of the immediate field and is ignored
  localparam logic [10:0] OPC_ADDI = 11'b10010001000;
  localparam logic [10:0] OPC_SUBI = 11'b11010001000;
  localparam logic [10:0] OPC_ANDI = 11'b10010010000;
  localparam logic [10:0] OPC_ORRI = 11'b10110010000;

endpackage

// File: rtl/alu_mem_datapath_dmem_array.sv
// dmem_array
// Data memory: DEPTH x 64-bit words, asynchronously cleared by reset,
// one synchronous write port and a combinational, enable-gated read port.
// Ports:
//   clk    - write clock (rising edge)
//   rst_n  - async active-low reset, clears every word
//   addr   - word index
//   wdata  - write data
//   we     - write enable
//   re     - read enable; rdata is 0 when low
//   rdata  - read data
module dmem_array #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  input  logic          we,
  input  logic          re,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Cleared by reset, set by the first rising edge after release. A write
  // presented on the edge where reset was released during that cycle is
  // therefore dropped; writes start on the following edge.
  logic wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ok <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      wr_ok <= 1'b1;
      if (we && wr_ok) begin
        mem[addr] <= wdata;
      end
    end
  end

  assign rdata = re ? mem[addr] : 64'd0;

endmodule

// File: rtl/alu_mem_datapath.sv
// alu_mem_datapath
// Execute-and-memory slice of the single-cycle LEGv8 processor: ALU control
// decode, 64-bit ALU with zero flag, and the data memory addressed by the
// ALU result.
// Ports:
//   CLK, Reset_L    - clock; async active-low reset (clears data memory)
//   ALUOp, opcode   - main-control class and instruction bits [31:21]
//   busA, aluB      - ALU operands
//   busB            - store data
//   MemRead/Write   - data memory enables
//   ALUCtrl         - decoded ALU operation
//   ALUResult       - ALU output, also the memory byte address
//   ALUZero         - ALUResult == 0
//   dMemOut         - memory read data (0 when MemRead is low)
module alu_mem_datapath
  import alu_mem_datapath_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [1:0]  ALUOp,
  input  logic [10:0] opcode,
  input  logic [63:0] busA,
  input  logic [63:0] aluB,
  input  logic [63:0] busB,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [63:0] ALUResult,
  output logic        ALUZero,
  output logic [63:0] dMemOut
);

  localparam int AW = $clog2(DEPTH);

  // ALU control decode
  always_comb begin
    ALUCtrl = ALU_INVALID;
    case (alu_op_e'(ALUOp))
      ALUOP_MEM: ALUCtrl = ALU_ADD;
      ALUOP_CBZ: ALUCtrl = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: ALUCtrl = ALU_ADD;
          OPC_SUB: ALUCtrl = ALU_SUB;
          OPC_AND: ALUCtrl = ALU_AND;
          OPC_ORR: ALUCtrl = ALU_OR;
          default: ALUCtrl = ALU_INVALID;
        endcase
      end
      ALUOP_ITYPE: begin
        case (opcode[10:1])
          OPC_ADDI[10:1]: ALUCtrl = ALU_ADD;
          OPC_SUBI[10:1]: ALUCtrl = ALU_SUB;
          OPC_ANDI[10:1]: ALUCtrl = ALU_AND;
          OPC_ORRI[10:1]: ALUCtrl = ALU_OR;
          default:        ALUCtrl = ALU_INVALID;
        endcase
      end
      default: ALUCtrl = ALU_INVALID;
    endcase
  end

  // ALU; undefined codes produce 0 so the zero flag reads 1
  always_comb begin
    ALUResult = 64'd0;
    case (alu_ctrl_e'(ALUCtrl))
      ALU_AND:   ALUResult = busA & aluB;
      ALU_OR:    ALUResult = busA | aluB;
      ALU_ADD:   ALUResult = busA + aluB;
      ALU_SUB:   ALUResult = busA - aluB;
      ALU_PASSB: ALUResult = aluB;
      default:   ALUResult = 64'd0;
    endcase
  end

  assign ALUZero = (ALUResult == 64'd0);

  // Byte address -> word index; low 3 bits and upper bits alias away
  logic [AW-1:0] word_idx;
  assign word_idx = ALUResult[AW+2:3];

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (CLK),
    .rst_n (Reset_L),
    .addr  (word_idx),
    .wdata (busB),
    .we    (MemWrite),
    .re    (MemRead),
    .rdata (dMemOut)
  );

endmodule

// File: tb/tb_alu_mem_datapath.sv
module tb_alu_mem_datapath;

  localparam int DEPTH = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_ANDI = 11'b10010010001;
  localparam logic [10:0] OP_ORRI = 11'b10110010001;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  logic        CLK;
  logic        Reset_L;
  logic [1:0]  ALUOp;
  logic [10:0] opcode;
  logic [63:0] busA;
  logic [63:0] aluB;
  logic [63:0] busB;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  ALUCtrl;
  logic [63:0] ALUResult;
  logic        ALUZero;
  logic [63:0] dMemOut;

  int vectors;
  int miscompares;

  alu_mem_datapath #(
    .DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .ALUOp     (ALUOp),
    .opcode    (opcode),
    .busA      (busA),
    .aluB      (aluB),
    .busB      (busB),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUCtrl   (ALUCtrl),
    .ALUResult (ALUResult),
    .ALUZero   (ALUZero),
    .dMemOut   (dMemOut)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // driver tasks
  task automatic drive_alu(input logic [1:0] op, input logic [10:0] opc,
                           input logic [63:0] a, input logic [63:0] b);
    ALUOp  = op;
    opcode = opc;
    busA   = a;
    aluB   = b;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_alu(input string tag, input logic [3:0] ctrl,
                         input logic [63:0] res, input logic zero);
    chk({tag, ".ctrl"}, {60'd0, ALUCtrl}, {60'd0, ctrl});
    chk({tag, ".res"},  ALUResult, res);
    chk({tag, ".zero"}, {63'd0, ALUZero}, {63'd0, zero});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_L  = 1'b0;
    MemRead  = 1'b1;
    MemWrite = 1'b1;        // write attempts during reset must be blocked
    busB     = 64'h1111_2222_3333_4444;
    drive_alu(2'b00, 11'd0, 64'h10, 64'h8);

    // reset state: address 0x18 reads 0
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    chk_alu("reset_addr", 4'b0010, 64'h18, 1'b0);
    chk("reset_read", dMemOut, 64'd0);

    // release reset with a write pending: that edge's write is suppressed
    Reset_L = 1'b1;
    @(posedge CLK); #1;
    chk("release_write_suppressed", dMemOut, 64'd0);

    // next edge writes; before the edge the old word is visible
    @(negedge CLK);
    busB = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("rdw_old_word", dMemOut, 64'd0);
    @(posedge CLK); #1;
    chk("rdw_new_word", dMemOut, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge CLK);
    MemWrite = 1'b0;
    busB     = 64'd0;

    // load with low address bits set
    drive_alu(2'b00, 11'd0, 64'h13, 64'h8);
    chk("addr_1b", ALUResult, 64'h1B);
    chk("load_1b", dMemOut, 64'hDEAD_BEEF_CAFE_F00D);
    // aliasing modulo 8*DEPTH bytes
    drive_alu(2'b00, 11'd0, 64'h18 + 64'(8 * DEPTH), 64'h0);
    chk("load_alias", dMemOut, 64'hDEAD_BEEF_CAFE_F00D);
    // neighbouring word untouched
    drive_alu(2'b00, 11'd0, 64'h20, 64'h0);
    chk("load_other", dMemOut, 64'd0);
    // read disabled
    drive_alu(2'b00, 11'd0, 64'h18, 64'h0);
    MemRead = 1'b0;
    #1;
    chk("read_disabled", dMemOut, 64'd0);
    MemRead = 1'b1;
    #1;
    chk("read_enabled", dMemOut, 64'hDEAD_BEEF_CAFE_F00D);

    // ALU control / ALU vectors
    drive_alu(2'b10, OP_ADD, 64'd5, 64'd7);
    chk_alu("add", 4'b0010, 64'd12, 1'b0);
    drive_alu(2'b10, OP_SUB, 64'h1234, 64'h1234);
    chk_alu("sub_zero", 4'b0110, 64'd0, 1'b1);
    drive_alu(2'b10, OP_SUB, 64'd0, 64'd1);
    chk_alu("sub_wrap", 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drive_alu(2'b10, OP_AND, 64'hFF00_FF00_0000_0001, 64'h0F0F_0F0F_0000_0003);
    chk_alu("and", 4'b0000, 64'h0F00_0F00_0000_0001, 1'b0);
    drive_alu(2'b10, OP_ORR, 64'hA000_0000_0000_0000, 64'h0000_0000_0000_0005);
    chk_alu("orr", 4'b0001, 64'hA000_0000_0000_0005, 1'b0);
    drive_alu(2'b11, OP_ANDI, 64'hF0F0, 64'hFF);
    chk_alu("andi", 4'b0000, 64'hF0, 1'b0);
    drive_alu(2'b11, OP_ORRI, 64'hF0F0, 64'hFF);
    chk_alu("orri", 4'b0001, 64'hF0FF, 1'b0);
    drive_alu(2'b11, OP_ADDI, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk_alu("addi_wrap", 4'b0010, 64'd0, 1'b1);
    drive_alu(2'b11, OP_SUBI, 64'd100, 64'd58);
    chk_alu("subi", 4'b0110, 64'd42, 1'b0);
    drive_alu(2'b01, OP_BAD, 64'h1234, 64'd0);
    chk_alu("cbz_zero", 4'b0111, 64'd0, 1'b1);
    drive_alu(2'b01, OP_BAD, 64'h1234, 64'h55);
    chk_alu("cbz_nonzero", 4'b0111, 64'h55, 1'b0);
    drive_alu(2'b10, OP_BAD, 64'd5, 64'd7);
    chk_alu("rtype_unknown", 4'b1111, 64'd0, 1'b1);
    // I-type opcode under R-type class is not recognised
    drive_alu(2'b10, OP_ADDI, 64'd5, 64'd7);
    chk_alu("rtype_with_addi", 4'b1111, 64'd0, 1'b1);
    // R-type opcode under I-type class is not recognised
    drive_alu(2'b11, OP_ADD, 64'd5, 64'd7);
    chk_alu("itype_with_add", 4'b1111, 64'd0, 1'b1);

    // async reset mid-cycle clears memory without a clock edge
    drive_alu(2'b00, 11'd0, 64'h18, 64'h0);
    @(negedge CLK); #1;
    chk("pre_reset_read", dMemOut, 64'hDEAD_BEEF_CAFE_F00D);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("async_reset_read", dMemOut, 64'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK); #1;
    chk("post_reset_read", dMemOut, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // overall time bound
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
